cpu_fetch_queue: RTL and testbench

//  Next-generation instruction fetch stage: decouples the instruction cache from decode

---
 rtl/cpu_fetch_queue.sv | 290 +++++++++++++++++++++++++++++
 tb/tb_cpu_fetch_queue.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_fetch_queue.sv
// Instruction fetch stage: DEPTH-entry prefetch queue between icache and decode, early register
// index decode, branch/ECALL/WFI holds, redirects and edge-triggered interrupt dispatch.
// Optional macro FETCH_STATIC_BP_EN enables static prediction of the post-branch fetch hint.
module cpu_fetch_queue #(
    parameter logic [31:0] RESET_VECTOR = 32'h0,
    parameter int          DEPTH        = 4
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_jump,
    input  logic [31:0] i_jump_pc,
    input  logic        i_irq_pending,
    input  logic [31:0] i_irq_pc,
    output logic        o_irq_dispatched,
    output logic [31:0] o_irq_epc,
    output logic [31:0] o_icache_pc,
    input  logic        i_icache_ready,
    input  logic [31:0] i_icache_rdata,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [31:0] o_pc,
    output logic [31:0] o_instruction,
    output logic [4:0]  o_rs1,
    output logic [4:0]  o_rs2,
    output logic [4:0]  o_rs3,
    output logic [4:0]  o_rd
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    localparam logic [31:0] INSN_ECALL = 32'h0000_0073;
    localparam logic [31:0] INSN_WFI   = 32'h1050_0073;
    localparam logic [31:0] INSN_MRET  = 32'h3020_0073;

    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        ST_FETCH     = 2'd0,
        ST_WAIT_JUMP = 2'd1,
        ST_WAIT_IRQ  = 2'd2
    } state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rs3;
        logic [4:0]  rd;
    } entry_t;

    state_e           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             irq_prev_q;
    logic             irq_latched_q, irq_latched_d;
    logic             irq_disp_q;
    logic [31:0]      irq_epc_q, irq_epc_d;
    entry_t           ent_q [DEPTH];

    logic        fetch_en;
    logic        irq_ok;
    logic        transfer;
    logic        irq_pending;
    logic        dispatch;
    logic        flush;
    logic        room;
    logic        enq;
    logic [6:0]  opcode;
    logic        is_jal;
    logic        is_branch;
    logic        is_ctrl;
    logic        is_wait;
    logic [31:0] pc_plus4;
    logic [31:0] hint;
    logic [4:0]  dec_rs1, dec_rs2, dec_rs3, dec_rd;
    entry_t      head_ent;

    // ------------------------------------------------------------------
    // Handshake, interrupt edge and enqueue qualification
    // ------------------------------------------------------------------
    assign o_valid   = (count_q != '0);
    assign transfer  = o_valid & i_ready;

    // A pending edge waits in irq_latched_q while dispatch is not allowed.
    assign irq_pending = irq_latched_q | (i_irq_pending & ~irq_prev_q);
    assign dispatch    = irq_pending & irq_ok & ~i_jump & ~transfer;
    assign flush       = i_jump | dispatch;
    assign room        = (count_q != DEPTH_CNT) | transfer;
    assign enq         = fetch_en & i_icache_ready & room & ~flush;

    // ------------------------------------------------------------------
    // Instruction classification and register-index extraction
    // ------------------------------------------------------------------
    assign opcode    = i_icache_rdata[6:0];
    assign is_jal    = (opcode == OPC_JAL);
    assign is_branch = (opcode == OPC_BRANCH);
    assign is_ctrl   = is_jal | is_branch | (opcode == OPC_JALR) | (i_icache_rdata == INSN_MRET);
    assign is_wait   = (i_icache_rdata == INSN_ECALL) | (i_icache_rdata == INSN_WFI);
    assign pc_plus4  = pc_q + 32'd4;

    always_comb begin
        dec_rs1 = '0;
        dec_rs2 = '0;
        dec_rs3 = '0;
        dec_rd  = '0;
        case (opcode)
            7'b0110011, 7'b0111011, 7'b1010011, 7'b0101111: begin
                dec_rs1 = i_icache_rdata[19:15];
                dec_rs2 = i_icache_rdata[24:20];
                dec_rd  = i_icache_rdata[11:7];
            end
            7'b1000011, 7'b1000111, 7'b1001011, 7'b1001111: begin
                dec_rs1 = i_icache_rdata[19:15];
                dec_rs2 = i_icache_rdata[24:20];
                dec_rs3 = i_icache_rdata[31:27];
                dec_rd  = i_icache_rdata[11:7];
            end
            7'b0010011, 7'b0011011, 7'b0000011, 7'b0000111, 7'b1100111, 7'b1110011: begin
                dec_rs1 = i_icache_rdata[19:15];
                dec_rd  = i_icache_rdata[11:7];
            end
            7'b0100011, 7'b0100111, 7'b1100011: begin
                dec_rs1 = i_icache_rdata[19:15];
                dec_rs2 = i_icache_rdata[24:20];
            end
            7'b0110111, 7'b0010111, 7'b1101111: begin
                dec_rd  = i_icache_rdata[11:7];
            end
            default: begin
                dec_rs1 = '0;
            end
        endcase
    end

`ifdef FETCH_STATIC_BP_EN
    logic [31:0] j_imm;
    logic [31:0] b_imm;

    assign j_imm = {{12{i_icache_rdata[31]}}, i_icache_rdata[19:12], i_icache_rdata[20],
                    i_icache_rdata[30:21], 1'b0};
    assign b_imm = {{20{i_icache_rdata[31]}}, i_icache_rdata[7], i_icache_rdata[30:25],
                    i_icache_rdata[11:8], 1'b0};

    // Backward branches are predicted taken, forward ones fall through.
    always_comb begin
        hint = pc_plus4;
        if (is_jal) begin
            hint = pc_q + j_imm;
        end else if (is_branch && b_imm[31]) begin
            hint = pc_q + b_imm;
        end
    end
`else
    assign hint = pc_plus4;
`endif

    // ------------------------------------------------------------------
    // FSM: state register / next state / state-decoded outputs
    // ------------------------------------------------------------------
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_FETCH;
        end else if (enq && is_ctrl) begin
            state_d = ST_WAIT_JUMP;
        end else if (enq && is_wait) begin
            state_d = ST_WAIT_IRQ;
        end
    end

    always_comb begin
        fetch_en = 1'b0;
        irq_ok   = 1'b0;
        case (state_q)
            ST_FETCH: begin
                fetch_en = 1'b1;
                irq_ok   = 1'b1;
            end
            ST_WAIT_IRQ: begin
                irq_ok   = 1'b1;
            end
            default: begin
                fetch_en = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state for PC, queue pointers and interrupt bookkeeping
    // ------------------------------------------------------------------
    // ECALL/WFI advance past themselves so the interrupt return lands after the wait.
    always_comb begin
        pc_d = pc_q;
        if (i_jump) begin
            pc_d = i_jump_pc;
        end else if (dispatch) begin
            pc_d = i_irq_pc;
        end else if (enq) begin
            pc_d = is_ctrl ? hint : pc_plus4;
        end
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = head_q + PTR_W'(transfer);
            tail_d  = tail_q + PTR_W'(enq);
            count_d = count_q + CNT_W'(enq) - CNT_W'(transfer);
        end
    end

    assign head_ent = ent_q[head_q];

    always_comb begin
        irq_latched_d = irq_pending & ~dispatch;
        irq_epc_d     = irq_epc_q;
        if (dispatch) begin
            irq_epc_d = o_valid ? head_ent.pc : pc_q;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            pc_q          <= RESET_VECTOR;
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            irq_prev_q    <= 1'b0;
            irq_latched_q <= 1'b0;
            irq_disp_q    <= 1'b0;
            irq_epc_q     <= '0;
        end else begin
            pc_q          <= pc_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            irq_prev_q    <= i_irq_pending;
            irq_latched_q <= irq_latched_d;
            irq_disp_q    <= dispatch;
            irq_epc_q     <= irq_epc_d;
        end
    end

    // Queue payload needs no reset: o_valid gates its meaning.
    always_ff @(posedge i_clock) begin
        if (enq) begin
            ent_q[tail_q] <= '{pc:    pc_q,
                               instr: i_icache_rdata,
                               rs1:   dec_rs1,
                               rs2:   dec_rs2,
                               rs3:   dec_rs3,
                               rd:    dec_rd};
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign o_icache_pc      = pc_q;
    assign o_irq_dispatched = irq_disp_q;
    assign o_irq_epc        = irq_epc_q;
    assign o_pc             = head_ent.pc;
    assign o_instruction    = head_ent.instr;
    assign o_rs1            = head_ent.rs1;
    assign o_rs2            = head_ent.rs2;
    assign o_rs3            = head_ent.rs3;
    assign o_rd             = head_ent.rd;

endmodule

// File: tb/tb_cpu_fetch_queue.sv
// Directed self-checking bench for cpu_fetch_queue (RESET_VECTOR=100h, DEPTH=4) with a
// combinational icache model answering o_icache_pc from a small instruction table.
module tb_cpu_fetch_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        jump;
    logic [31:0] jump_pc;
    logic        irq;
    logic [31:0] irq_pc;
    logic        irq_disp;
    logic [31:0] irq_epc;
    logic [31:0] icache_pc;
    logic        icache_ready;
    logic [31:0] icache_rdata;
    logic        valid;
    logic        ready;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  rs1, rs2, rs3, rd;

    int n_checks = 0;
    int n_errors = 0;
    int disp_cnt = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] WFI = 32'h1050_0073;

    logic [31:0] t_word [8];
    logic [4:0]  t_rs1  [8];
    logic [4:0]  t_rs2  [8];
    logic [4:0]  t_rs3  [8];
    logic [4:0]  t_rd   [8];
    logic [31:0] beq_word;
    logic [31:0] exp_hint;
    int          cnt0;

    always #5 clk = ~clk;

    cpu_fetch_queue #(
        .RESET_VECTOR (32'h100),
        .DEPTH        (4)
    ) dut (
        .i_clock          (clk),
        .i_reset          (rst),
        .i_jump           (jump),
        .i_jump_pc        (jump_pc),
        .i_irq_pending    (irq),
        .i_irq_pc         (irq_pc),
        .o_irq_dispatched (irq_disp),
        .o_irq_epc        (irq_epc),
        .o_icache_pc      (icache_pc),
        .i_icache_ready   (icache_ready),
        .i_icache_rdata   (icache_rdata),
        .o_valid          (valid),
        .i_ready          (ready),
        .o_pc             (pc),
        .o_instruction    (instr),
        .o_rs1            (rs1),
        .o_rs2            (rs2),
        .o_rs3            (rs3),
        .o_rd             (rd)
    );

    always_comb begin
        icache_rdata = NOP;
        if (icache_pc >= 32'h100 && icache_pc < 32'h120) begin
            icache_rdata = t_word[icache_pc[4:2]];
        end else if (icache_pc == 32'h200) begin
            icache_rdata = beq_word;
        end else if (icache_pc == 32'h500) begin
            icache_rdata = WFI;
        end
    end

    always @(negedge clk) begin
        if (!rst && irq_disp) disp_cnt <= disp_cnt + 1;
    end

    function automatic logic [31:0] r_type(input logic [6:0] opc, input logic [4:0] d,
                                           input logic [4:0] s1, input logic [4:0] s2);
        return {7'b0, s2, s1, 3'b000, d, opc};
    endfunction

    function automatic logic [31:0] i_type(input logic [6:0] opc, input logic [4:0] d,
                                           input logic [4:0] s1, input logic [11:0] imm);
        return {imm, s1, 3'b000, d, opc};
    endfunction

    function automatic logic [31:0] s_type(input logic [4:0] s1, input logic [4:0] s2,
                                           input logic [11:0] imm);
        return {imm[11:5], s2, s1, 3'b010, imm[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] r4_type(input logic [4:0] d, input logic [4:0] s1,
                                            input logic [4:0] s2, input logic [4:0] s3);
        return {s3, 2'b00, s2, s1, 3'b000, d, 7'b1000011};
    endfunction

    function automatic logic [31:0] b_type(input logic [4:0] s1, input logic [4:0] s2,
                                           input logic [12:0] imm);
        return {imm[12], imm[10:5], s2, s1, 3'b000, imm[4:1], imm[11], 7'b1100011};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("  ok   %-16s %h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Decode table for 100h..11Ch: expected indices written out by hand.
        t_word[0] = r_type(7'b0110011, 5'd3, 5'd1, 5'd2);       t_rs1[0] = 5'd1;  t_rs2[0] = 5'd2;  t_rs3[0] = 5'd0;  t_rd[0] = 5'd3;
        t_word[1] = i_type(7'b0010011, 5'd5, 5'd4, 12'd7);      t_rs1[1] = 5'd4;  t_rs2[1] = 5'd0;  t_rs3[1] = 5'd0;  t_rd[1] = 5'd5;
        t_word[2] = s_type(5'd6, 5'd7, 12'h01F);                t_rs1[2] = 5'd6;  t_rs2[2] = 5'd7;  t_rs3[2] = 5'd0;  t_rd[2] = 5'd0;
        t_word[3] = {20'hABCDE, 5'd9, 7'b0110111};              t_rs1[3] = 5'd0;  t_rs2[3] = 5'd0;  t_rs3[3] = 5'd0;  t_rd[3] = 5'd9;
        t_word[4] = r4_type(5'd10, 5'd11, 5'd12, 5'd13);        t_rs1[4] = 5'd11; t_rs2[4] = 5'd12; t_rs3[4] = 5'd13; t_rd[4] = 5'd10;
        t_word[5] = r_type(7'b0110011, 5'd16, 5'd14, 5'd15);    t_rs1[5] = 5'd14; t_rs2[5] = 5'd15; t_rs3[5] = 5'd0;  t_rd[5] = 5'd16;
        t_word[6] = i_type(7'b0000011, 5'd17, 5'd18, 12'd4);    t_rs1[6] = 5'd18; t_rs2[6] = 5'd0;  t_rs3[6] = 5'd0;  t_rd[6] = 5'd17;
        t_word[7] = r_type(7'b0110011, 5'd31, 5'd30, 5'd29);    t_rs1[7] = 5'd30; t_rs2[7] = 5'd29; t_rs3[7] = 5'd0;  t_rd[7] = 5'd31;
        beq_word  = b_type(5'd1, 5'd2, 13'h1FF8);
`ifdef FETCH_STATIC_BP_EN
        exp_hint  = 32'h1F8;
`else
        exp_hint  = 32'h204;
`endif

        rst = 1'b1; jump = 1'b0; jump_pc = '0; irq = 1'b0; irq_pc = '0;
        icache_ready = 1'b1; ready = 1'b1;

        // 1: reset state, then eight decoded instructions streamed one per cycle
        tick(); tick();
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_disp", 32'(irq_disp), 32'd0);
        check("rst_epc", irq_epc, 32'h0);
        check("rst_icache_pc", icache_pc, 32'h100);
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            check($sformatf("s1_valid%0d", k), 32'(valid), 32'd1);
            check($sformatf("s1_pc%0d", k), pc, 32'h100 + 32'(4 * k));
            check($sformatf("s1_instr%0d", k), instr, t_word[k]);
            check($sformatf("s1_rs1_%0d", k), 32'(rs1), 32'(t_rs1[k]));
            check($sformatf("s1_rs2_%0d", k), 32'(rs2), 32'(t_rs2[k]));
            check($sformatf("s1_rs3_%0d", k), 32'(rs3), 32'(t_rs3[k]));
            check($sformatf("s1_rd_%0d", k), 32'(rd), 32'(t_rd[k]));
        end

        // 2: decode stalls, queue saturates at four, then drains in order
        rst = 1'b1; ready = 1'b0;
        tick();
        rst = 1'b0;
        repeat (10) tick();
        check("s2_hold_pc", icache_pc, 32'h110);
        check("s2_full_valid", 32'(valid), 32'd1);
        ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("s2_drain%0d", k), pc, 32'h100 + 32'(4 * k));
            tick();
        end

        // 3: backward branch stops enqueue until redirect
        jump = 1'b1; jump_pc = 32'h200;
        tick();
        jump = 1'b0;
        check("s3_flush_valid", 32'(valid), 32'd0);
        check("s3_redirect_pc", icache_pc, 32'h200);
        tick();
        check("s3_br_pc", pc, 32'h200);
        check("s3_hint", icache_pc, exp_hint);
        check("s3_br_rd", 32'(rd), 32'd0);
        check("s3_br_rs2", 32'(rs2), 32'd2);
        tick(); tick();
        check("s3_wait_valid", 32'(valid), 32'd0);
        check("s3_wait_pc", icache_pc, exp_hint);
        jump = 1'b1; jump_pc = 32'h300;
        tick();
        jump = 1'b0;
        tick();
        check("s3_jump_valid", 32'(valid), 32'd1);
        check("s3_jump_pc", pc, 32'h300);

        // 4: interrupt with 400h,404h queued
        ready = 1'b0;
        jump = 1'b1; jump_pc = 32'h400;
        tick();
        jump = 1'b0;
        tick(); tick();
        icache_ready = 1'b0;
        check("s4_head", pc, 32'h400);
        check("s4_fetch_pc", icache_pc, 32'h408);
        irq = 1'b1; irq_pc = 32'h80;
        tick();
        check("s4_disp", 32'(irq_disp), 32'd1);
        check("s4_epc", irq_epc, 32'h400);
        check("s4_flush_valid", 32'(valid), 32'd0);
        check("s4_vector", icache_pc, 32'h80);
        icache_ready = 1'b1; ready = 1'b1;
        tick();
        check("s4_disp_pulse", 32'(irq_disp), 32'd0);
        check("s4_handler_pc", pc, 32'h80);
        cnt0 = disp_cnt;
        repeat (6) tick();
        check("s4_level_no_redisp", 32'(disp_cnt - cnt0), 32'd0);
        irq = 1'b0;
        tick();

        // 5: WFI wait, then jump and IRQ edge together
        jump = 1'b1; jump_pc = 32'h500;
        tick();
        jump = 1'b0;
        tick();
        check("s5_wfi_pc", pc, 32'h500);
        tick(); tick();
        check("s5_wait_valid", 32'(valid), 32'd0);
        check("s5_wait_pc", icache_pc, 32'h504);
        tick();
        cnt0 = disp_cnt;
        irq = 1'b1; irq_pc = 32'h80;
        tick();
        check("s5_disp", 32'(irq_disp), 32'd1);
        check("s5_epc", irq_epc, 32'h504);
        repeat (3) tick();
        check("s5_one_disp", 32'(disp_cnt - cnt0), 32'd1);
        irq = 1'b0;
        tick();
        jump = 1'b1; jump_pc = 32'h600; irq = 1'b1; irq_pc = 32'h90;
        tick();
        jump = 1'b0;
        check("s5_jump_first", 32'(irq_disp), 32'd0);
        check("s5_jump_pc", icache_pc, 32'h600);
        tick();
        check("s5_late_disp", 32'(irq_disp), 32'd1);
        check("s5_late_epc", irq_epc, 32'h600);
        check("s5_late_vector", icache_pc, 32'h90);

        // 6: reset with a full queue
        irq = 1'b0; ready = 1'b0;
        repeat (6) tick();
        check("s6_full_valid", 32'(valid), 32'd1);
        check("s6_full_head", pc, 32'h90);
        rst = 1'b1;
        tick();
        check("s6_rst_valid", 32'(valid), 32'd0);
        check("s6_rst_epc", irq_epc, 32'h0);
        check("s6_rst_pc", icache_pc, 32'h100);
        rst = 1'b0; ready = 1'b1;
        tick();
        check("s6_restart_pc", pc, 32'h100);
        check("s6_restart_valid", 32'(valid), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
